// File: rtl/sdram_bridge_pkg.sv
// sdram_bridge_pkg: shared state encoding, controller width and lane-count helper
package sdram_bridge_pkg;
  localparam int CTRL_DW = 32;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_ARM, WR_REQ, DONE} state_t;
  function automatic int lanes(input int cpu_dw);
    return CTRL_DW / cpu_dw;
  endfunction
endpackage

// File: rtl/sdram_lane_mux.sv
// sdram_lane_mux: places a CPU word into a 32-bit lane, builds its byte mask and extracts a lane
module sdram_lane_mux
  import sdram_bridge_pkg::*;
#(
  parameter int CPU_DW = 8
) (
  input  logic [$clog2(lanes(CPU_DW))-1:0] lane,
  input  logic [CPU_DW-1:0]                wdata,
  input  logic [CTRL_DW-1:0]               word,
  output logic [CTRL_DW-1:0]               din,
  output logic [3:0]                       dm,
  output logic [CPU_DW-1:0]                rdata,
  output logic [CTRL_DW-1:0]               merged
);
  localparam int BPL = CPU_DW / 8;
  logic [CTRL_DW-1:0] lane_bits;
  // Shift write data into its lane, mask off the others, extract and merge the addressed lane
  always_comb begin
    din = '0;
    din[lane*CPU_DW +: CPU_DW] = wdata;
    lane_bits = '0;
    lane_bits[lane*CPU_DW +: CPU_DW] = '1;
    dm = '1;
    dm[lane*BPL +: BPL] = '0;
    rdata = word[lane*CPU_DW +: CPU_DW];
    merged = (word & ~lane_bits) | din;
  end
endmodule

// File: rtl/sdram_bridge.sv
// sdram_bridge: CPU-phase 8/16-bit bus to 32-bit SDRAM controller bridge with a one-word read buffer
module sdram_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int CPU_DW = 8,
  parameter int ADDR_W = 25,
  parameter int RD_BUF = 1
) (
  input  logic               i_sysclk,
  input  logic               i_rst,
  input  logic               i_cpuclk,
  input  logic               i_cs,
  input  logic               i_rwb,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [CPU_DW-1:0]  i_data,
  output logic [CPU_DW-1:0]  o_data,
  output logic               o_wait,
  output logic               o_we,
  output logic               o_re,
  output logic               o_last,
  output logic [ADDR_W-2:0]  o_addr,
  output logic [CTRL_DW-1:0] o_din,
  output logic [3:0]         o_dm,
  input  logic [CTRL_DW-1:0] i_dout,
  input  logic               i_wr_ack,
  input  logic               i_rd_ack,
  input  logic               i_rd_valid,
  input  logic               i_ref_req
);
  localparam int LW = $clog2(lanes(CPU_DW));
  state_t state, next;
  logic start, tag_hit, buf_valid;
  logic [ADDR_W-3:0] buf_tag;
  logic [CTRL_DW-1:0] buf_word, mux_word, din, merged;
  logic [LW-1:0] lat_lane, mux_lane;
  logic [3:0] dm;
  logic [CPU_DW-1:0] rdata;

  // In IDLE the mux serves the live CPU access against the buffer; afterwards it extracts from controller data
  sdram_lane_mux #(.CPU_DW(CPU_DW)) u_mux (
    .lane(mux_lane),
    .wdata(i_data),
    .word(mux_word),
    .din(din),
    .dm(dm),
    .rdata(rdata),
    .merged(merged)
  );

  // Next state, CPU stall and mux selection
  always_comb begin
    tag_hit = (RD_BUF != 0) && buf_valid && (buf_tag == i_addr[ADDR_W-1:2]);
    start = (state == IDLE) && i_cs && i_cpuclk && !i_ref_req;
    o_wait = i_cs && (state != DONE);
    mux_lane = (state == IDLE) ? i_addr[1 -: LW] : lat_lane;
    mux_word = (state == IDLE) ? buf_word : i_dout;
    next = state;
    unique case (state)
      IDLE:    next = !start ? IDLE : !i_rwb ? WR_ARM : tag_hit ? DONE : RD_REQ;
      RD_REQ:  next = i_rd_ack ? RD_DATA : RD_REQ;
      RD_DATA: next = i_rd_valid ? DONE : RD_DATA;
      WR_ARM:  next = i_cpuclk ? WR_ARM : WR_REQ;
      WR_REQ:  next = i_wr_ack ? DONE : WR_REQ;
      DONE:    next = i_cpuclk ? DONE : IDLE;
      default: next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_sysclk) begin
    if (i_rst) state <= IDLE;
    else state <= next;
  end

  // Registered strobes follow the next state so a reset clears them on the very next edge
  always_ff @(posedge i_sysclk) begin
    if (i_rst) begin
      o_data <= '0;
      o_we <= 1'b0;
      o_re <= 1'b0;
      o_last <= 1'b0;
      o_addr <= '0;
      o_din <= '0;
      o_dm <= 4'hF;
      lat_lane <= '0;
      buf_valid <= 1'b0;
      buf_tag <= '0;
      buf_word <= '0;
    end else begin
      o_re <= next == RD_REQ;
      o_we <= next == WR_REQ;
      o_last <= (next == RD_REQ) || (next == WR_REQ);
      if (start) begin
        o_addr <= {i_addr[ADDR_W-1:2], 1'b0};
        o_din <= din;
        o_dm <= dm;
        lat_lane <= i_addr[1 -: LW];
      end
      if (start && i_rwb && tag_hit) o_data <= rdata;
      if (start && !i_rwb && tag_hit) buf_word <= merged;
      if (state == RD_DATA && i_rd_valid) begin
        o_data <= rdata;
        if (RD_BUF != 0) begin
          buf_valid <= 1'b1;
          buf_tag <= o_addr[ADDR_W-2:1];
          buf_word <= i_dout;
        end
      end
    end
  end
endmodule

// File: tb/tb_sdram_bridge.sv
// tb_sdram_bridge: randomized scoreboard bench with a byte-memory reference model and a behavioural controller
module tb_sdram_bridge;
  typedef struct packed {logic hit; logic [7:0] data;} rexp_t;
  typedef struct packed {logic [23:0] addr; logic [31:0] din; logic [3:0] dm;} wexp_t;

  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  logic cs = 0, rwb = 0, cpuclk = 0, ref_req = 0;
  logic [24:0] addr = '0;
  logic [7:0] wdata = '0, odata;
  logic wt, we, re, last, wack = 0, rack = 0, rvalid = 0;
  logic [23:0] oaddr;
  logic [31:0] din, dout = '0;
  logic [3:0] dm;

  logic h_cs = 0, h_rwb = 0, h_cpuclk = 0, h_ref = 0;
  logic [24:0] h_addr = '0;
  logic [15:0] h_wdata = '0, h_odata;
  logic h_wait, h_we, h_re, h_last, h_wack = 0, h_rack = 0, h_rvalid = 0;
  logic [23:0] h_oaddr;
  logic [31:0] h_din, h_dout = '0;
  logic [3:0] h_dm;

  sdram_bridge dut (
    .i_sysclk(clk), .i_rst(rst), .i_cpuclk(cpuclk), .i_cs(cs), .i_rwb(rwb), .i_addr(addr),
    .i_data(wdata), .o_data(odata), .o_wait(wt), .o_we(we), .o_re(re), .o_last(last),
    .o_addr(oaddr), .o_din(din), .o_dm(dm), .i_dout(dout), .i_wr_ack(wack), .i_rd_ack(rack),
    .i_rd_valid(rvalid), .i_ref_req(ref_req)
  );

  sdram_bridge #(.CPU_DW(16)) dut16 (
    .i_sysclk(clk), .i_rst(rst), .i_cpuclk(h_cpuclk), .i_cs(h_cs), .i_rwb(h_rwb), .i_addr(h_addr),
    .i_data(h_wdata), .o_data(h_odata), .o_wait(h_wait), .o_we(h_we), .o_re(h_re), .o_last(h_last),
    .o_addr(h_oaddr), .o_din(h_din), .o_dm(h_dm), .i_dout(h_dout), .i_wr_ack(h_wack), .i_rd_ack(h_rack),
    .i_rd_valid(h_rvalid), .i_ref_req(h_ref)
  );

  int passed = 0, total = 0, cyc = 0, issue_cyc = 0;
  logic [7:0] ref_mem [64];
  logic [31:0] mem_w [16];
  bit rb_valid = 0, re_seen = 0, hold_ack = 0;
  logic [5:0] rb_tag = '0;
  rexp_t rq[$];
  wexp_t wq[$];
  rexp_t mon_r;
  wexp_t ctl_w;
  int we_cnt = 0, we_dly = 0, re_cnt = 0, re_dly = 0, rv_cnt = 0, fix_dly = -1;
  logic [3:0] rd_idx = '0;

  always @(posedge clk) cyc++;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Behavioural SDRAM controller: random ack latency, word memory honouring the byte mask
  always @(negedge clk) begin
    wack = 0;
    rack = 0;
    rvalid = 0;
    dout = $urandom;
    if (we || re) check(!(we && re) && last, "strobe_excl", {re, we, last}, 3'b001);
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        rvalid = 1;
        dout = mem_w[rd_idx];
      end
    end
    if (we) begin
      if (we_cnt == 0) we_dly = (fix_dly >= 0) ? fix_dly : int'($urandom_range(0, 3));
      we_cnt++;
      if (we_cnt == we_dly + 1 && !hold_ack) begin
        if (wq.size() == 0) check(0, "wr_unexpected", {oaddr, din, dm}, 0);
        else begin
          ctl_w = wq.pop_front();
          check({oaddr, din, dm} == ctl_w, "wr_fields", {oaddr, din, dm}, ctl_w);
        end
        for (int b = 0; b < 4; b++) if (!dm[b]) mem_w[oaddr[4:1]][8*b +: 8] = din[8*b +: 8];
        wack = 1;
      end
    end else if (we_cnt != 0) begin
      if (!hold_ack) check(we_cnt == we_dly + 1, "we_hold", we_cnt, we_dly + 1);
      we_cnt = 0;
    end
    if (re) begin
      if (re_cnt == 0) re_dly = (fix_dly >= 0) ? fix_dly : int'($urandom_range(0, 3));
      re_cnt++;
      re_seen = 1;
      if (re_cnt == re_dly + 1) begin
        rack = 1;
        rd_idx = oaddr[4:1];
        rv_cnt = $urandom_range(1, 3);
      end
    end else if (re_cnt != 0) begin
      check(re_cnt == re_dly + 1, "re_hold", re_cnt, re_dly + 1);
      re_cnt = 0;
    end
  end

  // CPU-side monitor: compare read data and hit/miss path whenever the stall is released
  always @(negedge clk) begin
    if (cs && !wt) begin
      if (rwb) begin
        if (rq.size() == 0) check(0, "rd_unexpected", odata, 0);
        else begin
          mon_r = rq.pop_front();
          check(odata == mon_r.data, "rd_data", odata, mon_r.data);
          check(re_seen == !mon_r.hit, "rd_path", re_seen, !mon_r.hit);
          if (mon_r.hit) check(cyc - issue_cyc == 1, "hit_latency", cyc - issue_cyc, 1);
        end
      end
      re_seen = 0;
    end
  end

  task automatic access(input bit rw, input logic [7:0] a, input logic [7:0] d, input int refc);
    int n;
    bit h;
    logic [3:0] one;
    @(negedge clk);
    addr = 25'(a);
    wdata = d;
    rwb = rw;
    cs = 1;
    cpuclk = 1;
    ref_req = refc > 0;
    for (int k = 0; k < refc; k++) begin
      @(negedge clk);
      check(wt && !re && !we, "refresh_hold", {wt, re, we}, 3'b100);
    end
    ref_req = 0;
    if (rw) begin
      h = rb_valid && rb_tag == a[7:2];
      rq.push_back({h, ref_mem[a[5:0]]});
      if (!h) begin
        rb_valid = 1;
        rb_tag = a[7:2];
      end
    end else begin
      one = 4'b0001;
      ref_mem[a[5:0]] = d;
      wq.push_back({24'(a[7:2]) << 1, 32'(d) << (8 * a[1:0]), ~(one << a[1:0])});
    end
    issue_cyc = cyc;
    @(negedge clk);
    cpuclk = 0;
    n = 0;
    while (wt && n < 100) begin
      ref_req = $urandom_range(0, 3) == 0;
      @(negedge clk);
      n++;
    end
    if (n == 100) check(0, "wait_timeout", n, 0);
    ref_req = 0;
    @(negedge clk);
    cs = 0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) begin
      mem_w[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*i+b] = mem_w[i][8*b +: 8];
    end
    repeat (3) @(negedge clk);
    check(odata == 0 && !wt, "reset_data", {odata, wt}, 0);
    check(!we && !re && !last && dm == 4'hF, "reset_strobes", {we, re, last, dm}, 7'h0F);
    check(oaddr == 0 && din == 0, "reset_addr_din", {oaddr, din}, 0);
    rst = 0;
    @(negedge clk);
    h_addr = 25'h2;
    h_rwb = 1;
    h_cs = 1;
    h_cpuclk = 1;
    @(negedge clk);
    h_cpuclk = 0;
    check(h_re && h_last && h_wait, "h16_re_issue", {h_re, h_last, h_wait}, 3'b111);
    h_rack = 1;
    h_dout = 32'hDEADBEEF;
    @(negedge clk);
    h_rack = 0;
    check(!h_re && !h_last, "h16_re_drop", {h_re, h_last}, 0);
    h_rvalid = 1;
    h_dout = 32'h1234_5678;
    @(negedge clk);
    h_rvalid = 0;
    check(!h_wait && h_odata == 16'h1234, "h16_rd_data", {h_wait, h_odata}, 17'h01234);
    @(negedge clk);
    h_cs = 0;
    @(negedge clk);
    h_addr = 25'h0;
    h_rwb = 0;
    h_wdata = 16'hBEEF;
    h_cs = 1;
    h_cpuclk = 1;
    @(negedge clk);
    h_cpuclk = 0;
    @(negedge clk);
    check(h_we && h_din == 32'h0000_BEEF && h_dm == 4'b1100 && h_oaddr == 0, "h16_wr_fields",
          {h_we, h_din, h_dm, h_oaddr}, {1'b1, 32'h0000_BEEF, 4'b1100, 24'h0});
    h_wack = 1;
    @(negedge clk);
    h_wack = 0;
    check(!h_we && !h_wait && h_odata == 16'h1234, "h16_wr_done", {h_we, h_wait, h_odata}, 18'h01234);
    @(negedge clk);
    h_cs = 0;
    fix_dly = 3;
    access(0, 8'h03, 8'hA5, 0);
    fix_dly = 1;
    access(1, 8'h10, 8'h00, 0);
    access(1, 8'h11, 8'h00, 0);
    access(0, 8'h12, 8'h77, 0);
    access(1, 8'h12, 8'h00, 0);
    access(1, 8'h20, 8'h00, 3);
    access(1, 8'h10, 8'h00, 0);
    @(negedge clk);
    addr = 25'h13;
    wdata = 8'h5A;
    rwb = 0;
    cs = 1;
    cpuclk = 1;
    hold_ack = 1;
    @(negedge clk);
    cpuclk = 0;
    n = 0;
    while (!we && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(we, "wr_req_reached", we, 1);
    rst = 1;
    @(negedge clk);
    check(!we && !last && dm == 4'hF && odata == 0, "reset_midwrite", {we, last, dm, odata}, 14'h0F00);
    rst = 0;
    cs = 0;
    rb_valid = 0;
    @(negedge clk);
    hold_ack = 0;
    access(1, 8'h10, 8'h00, 0);
    fix_dly = -1;
    for (int i = 0; i < 300; i++)
      access(1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), 8'($urandom),
             ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0);
    repeat (5) @(negedge clk);
    check(rq.size() == 0, "rq_drain", rq.size(), 0);
    check(wq.size() == 0, "wq_drain", wq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sdram_bridge.md
SDRAM_BRIDGE -- requirements
Module: sdram_bridge

Interface
REQ-001 Parameters SHALL be: CPU_DW, default 8, CPU data width (8 or 16 only); ADDR_W, default 25, CPU byte-address width; RD_BUF, default 1, enables the one-word read buffer (0 = disabled).
REQ-002 The clock SHALL be i_sysclk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-003 The reset SHALL be i_rst, input, 1 bit, synchronous, active-high.
REQ-004 The CPU-side ports SHALL be:
- i_cpuclk, in, 1: CPU phase, synchronous to i_sysclk.
- i_cs, in, 1: chip select.
- i_rwb, in, 1: read=1, write=0.
- i_addr, in, ADDR_W: byte address.
- i_data, in, CPU_DW: write data.
- o_data, out, CPU_DW: read data.
- o_wait, out, 1: stall the CPU.
REQ-005 The controller-side ports SHALL be:
- o_we, out, 1; o_re, out, 1; o_last, out, 1: request strobes.
- o_addr, out, ADDR_W-1: word address.
- o_din, out, 32; o_dm, out, 4: write data and byte mask.
- i_dout, in, 32: read data.
- i_wr_ack, in, 1; i_rd_ack, in, 1; i_rd_valid, in, 1: acknowledges and read-data valid.
- i_ref_req, in, 1: refresh pending.

Function
REQ-006 Lanes SHALL be 32/CPU_DW; lane index = i_addr[1:0] (CPU_DW=8) or i_addr[1] (CPU_DW=16); o_addr = {i_addr[ADDR_W-1:2],1'b0}.
REQ-007 Writes SHALL place i_data in the selected lane of o_din; o_dm = 0 on the selected lane's bytes and 1 on all others; reads return i_dout[lane*CPU_DW +: CPU_DW].
REQ-008 The FSM states SHALL be IDLE, RD_REQ, RD_DATA, WR_ARM, WR_REQ, DONE.
REQ-009 IDLE: when i_cs & i_cpuclk & ~i_ref_req, latch address, lane, data and mask; go to RD_REQ (read, buffer miss), DONE (read, buffer hit), or WR_ARM (write).
REQ-010 A read buffer hit SHALL load o_data from the buffer on the transition edge and issue no controller request (latency 1 cycle).
REQ-011 RD_REQ: hold o_re=o_last=1 until i_rd_ack is sampled high, then drop both on the next edge and go to RD_DATA.
REQ-012 RD_DATA: on the first i_rd_valid, register the lane into o_data, store the 32-bit word and its tag in the buffer (if RD_BUF), and go to DONE.
REQ-013 WR_ARM: wait for i_cpuclk=0, then go to WR_REQ.
REQ-014 WR_REQ: hold o_we=o_last=1 with stable o_addr/o_din/o_dm until i_wr_ack is sampled high, then go to DONE.
REQ-015 A write whose tag matches the buffer SHALL update the buffered lane in the same cycle the write is latched (write-through); a non-matching write leaves the buffer untouched.
REQ-016 DONE: return to IDLE when i_cpuclk=0; a new access is never started from the same CPU phase.
REQ-017 o_wait SHALL be 1 while i_cs=1 and the state is not DONE; it is also 1 in IDLE while i_ref_req=1; it is 0 when i_cs=0.
REQ-018 o_re and o_we SHALL never both be 1; i_ref_req arriving mid-transfer SHALL NOT abort the transfer.
REQ-019 o_data SHALL hold its value except on a read completion.

Reset
REQ-020 i_rst SHALL set state=IDLE, o_data=0, o_we=o_re=o_last=0, o_addr=0, o_din=0, o_dm=4'hF, and invalidate the buffer; these strobe values take effect on the first edge, including mid-transfer.

Structure
REQ-021 Package sdram_bridge_pkg SHALL hold the state enum, CTRL_DW=32, and a function computing lanes from CPU_DW.
REQ-022 Lane shift/extract SHALL be a sub-module, sdram_lane_mux, parametrised by CPU_DW.

Verification
REQ-023 CPU_DW=8, write 8'hA5 to 0x0000003, i_wr_ack after 3 cycles -> o_we held 4 cycles, o_din=32'hA500_0000, o_dm=4'b0111, o_addr=0.
REQ-024 CPU_DW=16, read 0x0000002, i_dout=32'h1234_5678 -> o_data=16'h1234, o_re dropped one edge after i_rd_ack.
REQ-025 RD_BUF=1, read 0x10 then read 0x11 -> second read has no o_re and o_data=byte1 of the buffered word, wait released within 1 cycle.
REQ-026 After buffering 0x10, write 8'h77 to 0x12 then read 0x12 -> returns 8'h77 with no controller read.
REQ-027 i_ref_req=1 while in IDLE with i_cs=1 -> o_wait=1, no request; after i_ref_req falls, the access proceeds normally.
REQ-028 Assert i_rst during WR_REQ -> o_we=0 next edge, o_dm=4'hF, buffer invalid (the next read misses).
